// File: rtl/de_stage.sv
// Decode stage: field extraction, register scoreboard for RAW/WAW hazards,
// fetch hold control and a saturating stall-cycle counter.
module de_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] fe_pc,
  input  logic [31:0] fe_isn,
  input  logic        ex_stall,
  input  logic        ex_flush,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  output logic [1:0]  fe_ctr,
  output logic        de_valid,
  output logic [31:0] de_pc,
  output logic [5:0]  de_opcode,
  output logic [4:0]  de_rs,
  output logic [4:0]  de_rt,
  output logic [4:0]  de_dst,
  output logic        de_wr,
  output logic [15:0] de_imm,
  output logic [15:0] stall_cnt
);

  logic [5:0]  w_opcode;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [15:0] w_imm;
  logic [4:0]  w_dst;
  logic        w_wr;
  logic        w_rs_used;
  logic        w_rt_used;
  logic [31:0] w_wb_mask;
  logic [31:0] w_busy_eff;
  logic        w_hazard;
  logic        w_issue;
  logic [31:0] w_busy_nxt;

  logic [31:0] r_busy;
  logic        r_valid;
  logic [31:0] r_pc;
  logic [5:0]  r_opcode;
  logic [4:0]  r_rs;
  logic [4:0]  r_rt;
  logic [4:0]  r_dst;
  logic        r_wr;
  logic [15:0] r_imm;
  logic [15:0] r_stall_cnt;

  assign w_opcode = fe_isn[31:26];
  assign w_rs     = fe_isn[25:21];
  assign w_rt     = fe_isn[20:16];
  assign w_rd     = fe_isn[15:11];
  assign w_imm    = fe_isn[15:0];

  // Destination selection and source-usage classification by opcode
  always_comb begin
    w_dst     = '0;
    w_wr      = 1'b0;
    w_rs_used = 1'b1;
    w_rt_used = 1'b0;
    if (w_opcode == 6'h00) begin
      w_dst = w_rd;
      w_wr  = 1'b1;
    end else if ((w_opcode >= 6'h08 && w_opcode <= 6'h0F) ||
                 (w_opcode >= 6'h20 && w_opcode <= 6'h25)) begin
      w_dst = w_rt;
      w_wr  = 1'b1;
    end
    if (w_opcode == 6'h02 || w_opcode == 6'h03)
      w_rs_used = 1'b0;
    if (w_opcode == 6'h00 || w_opcode == 6'h04 || w_opcode == 6'h05 ||
        (w_opcode >= 6'h28 && w_opcode <= 6'h2B))
      w_rt_used = 1'b1;
  end

  // A register finishing writeback this cycle no longer counts as busy
  assign w_wb_mask  = wb_en ? (32'd1 << wb_rd) : '0;
  assign w_busy_eff = r_busy & ~w_wb_mask;

  assign w_hazard = (w_rs_used & w_busy_eff[w_rs]) |
                    (w_rt_used & w_busy_eff[w_rt]) |
                    (w_wr      & w_busy_eff[w_dst]);

  assign w_issue = ~w_hazard & ~ex_stall & ~ex_flush;

  // Fetch hold request; forced to advance while in reset
  always_comb begin
    fe_ctr = 2'b00;
    if (rst && !w_issue && !ex_flush)
      fe_ctr = 2'b10;
  end

  // Scoreboard update: writeback/flush clear first, issue set wins, r0 never busy
  always_comb begin
    w_busy_nxt = r_busy & ~w_wb_mask;
    if (ex_flush && r_valid && r_wr)
      w_busy_nxt[r_dst] = 1'b0;
    if (w_issue && w_wr)
      w_busy_nxt[w_dst] = 1'b1;
    w_busy_nxt[0] = 1'b0;
  end

  // Scoreboard register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_busy <= '0;
    else      r_busy <= w_busy_nxt;
  end

  // Decode output register: flush > stall (hold) > hazard (bubble) > issue
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_valid  <= 1'b0;
      r_pc     <= '0;
      r_opcode <= '0;
      r_rs     <= '0;
      r_rt     <= '0;
      r_dst    <= '0;
      r_wr     <= 1'b0;
      r_imm    <= '0;
    end else if (ex_flush) begin
      r_valid <= 1'b0;
    end else if (ex_stall) begin
      r_valid <= r_valid;
    end else if (w_hazard) begin
      r_valid <= 1'b0;
    end else begin
      r_valid  <= 1'b1;
      r_pc     <= fe_pc;
      r_opcode <= w_opcode;
      r_rs     <= w_rs;
      r_rt     <= w_rt;
      r_dst    <= w_dst;
      r_wr     <= w_wr;
      r_imm    <= w_imm;
    end
  end

  // Saturating count of fetch-hold cycles
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      r_stall_cnt <= '0;
    else if (fe_ctr == 2'b10 && r_stall_cnt != 16'hFFFF)
      r_stall_cnt <= r_stall_cnt + 16'd1;
  end

  assign de_valid  = r_valid;
  assign de_pc     = r_pc;
  assign de_opcode = r_opcode;
  assign de_rs     = r_rs;
  assign de_rt     = r_rt;
  assign de_dst    = r_dst;
  assign de_wr     = r_wr;
  assign de_imm    = r_imm;
  assign stall_cnt = r_stall_cnt;

endmodule

// File: tb/tb_de_stage.sv
// Directed bench for de_stage: hazard stall/bypass, ex_stall hold, flush,
// r0 handling, counter saturation and mid-stall reset.
module tb_de_stage;

  logic        clk;
  logic        rst;
  logic [31:0] fe_pc;
  logic [31:0] fe_isn;
  logic        ex_stall;
  logic        ex_flush;
  logic        wb_en;
  logic [4:0]  wb_rd;
  logic [1:0]  fe_ctr;
  logic        de_valid;
  logic [31:0] de_pc;
  logic [5:0]  de_opcode;
  logic [4:0]  de_rs;
  logic [4:0]  de_rt;
  logic [4:0]  de_dst;
  logic        de_wr;
  logic [15:0] de_imm;
  logic [15:0] stall_cnt;

  int unsigned checks;
  int unsigned errors;

  de_stage dut (
    .clk       (clk),
    .rst       (rst),
    .fe_pc     (fe_pc),
    .fe_isn    (fe_isn),
    .ex_stall  (ex_stall),
    .ex_flush  (ex_flush),
    .wb_en     (wb_en),
    .wb_rd     (wb_rd),
    .fe_ctr    (fe_ctr),
    .de_valid  (de_valid),
    .de_pc     (de_pc),
    .de_opcode (de_opcode),
    .de_rs     (de_rs),
    .de_rt     (de_rt),
    .de_dst    (de_dst),
    .de_wr     (de_wr),
    .de_imm    (de_imm),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance past the next rising edge; inputs driven afterwards apply to the following edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b0;
    fe_pc    = '0;
    fe_isn   = '0;
    ex_stall = 1'b0;
    ex_flush = 1'b0;
    wb_en    = 1'b0;
    wb_rd    = '0;

    // Reset state
    #3;
    chk("rst_valid", {31'd0, de_valid}, 32'd0);
    chk("rst_pc", de_pc, 32'd0);
    chk("rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("rst_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // addi r1,r0,5 issues on first cycle out of reset
    fe_pc = 32'h0; fe_isn = 32'h20010005;
    #1 chk("A_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    chk("A_valid", {31'd0, de_valid}, 32'd1);
    chk("A_dst", {27'd0, de_dst}, 32'd1);
    chk("A_wr", {31'd0, de_wr}, 32'd1);
    chk("A_opcode", {26'd0, de_opcode}, 32'h08);
    chk("A_imm", {16'd0, de_imm}, 32'd5);

    // add r2,r1,r1: RAW on r1, bubbles and counts stalls
    fe_pc = 32'h4; fe_isn = 32'h00211020;
    #1 chk("B_fe_ctr", {30'd0, fe_ctr}, 32'h2);
    step();
    chk("B_valid", {31'd0, de_valid}, 32'd0);
    chk("B_cnt1", {16'd0, stall_cnt}, 32'd1);
    step();
    chk("B_cnt2", {16'd0, stall_cnt}, 32'd2);

    // Writeback of r1 bypasses the hazard in the same cycle
    wb_en = 1'b1; wb_rd = 5'd1;
    #1 chk("C_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    wb_en = 1'b0; wb_rd = '0;
    chk("C_valid", {31'd0, de_valid}, 32'd1);
    chk("C_dst", {27'd0, de_dst}, 32'd2);
    chk("C_pc", de_pc, 32'h4);
    chk("C_cnt", {16'd0, stall_cnt}, 32'd2);

    // ex_stall for 3 cycles holds outputs
    fe_pc = 32'h8; fe_isn = 32'h20030009; ex_stall = 1'b1;
    #1 chk("D_fe_ctr", {30'd0, fe_ctr}, 32'h2);
    step(); step(); step();
    chk("D_pc", de_pc, 32'h4);
    chk("D_dst", {27'd0, de_dst}, 32'd2);
    chk("D_valid", {31'd0, de_valid}, 32'd1);
    chk("D_opcode", {26'd0, de_opcode}, 32'd0);
    chk("D_cnt", {16'd0, stall_cnt}, 32'd5);
    ex_stall = 1'b0;
    #1 chk("D_rel_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    chk("D_rel_pc", de_pc, 32'h8);
    chk("D_rel_dst", {27'd0, de_dst}, 32'd3);

    // addi r5 then flush; r5 must be released
    fe_pc = 32'hC; fe_isn = 32'h20050001;
    step();
    chk("E_dst", {27'd0, de_dst}, 32'd5);
    chk("E_wr", {31'd0, de_wr}, 32'd1);
    ex_flush = 1'b1; fe_pc = 32'h10; fe_isn = 32'h00A53020;
    #1 chk("E_flush_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    chk("E_flush_valid", {31'd0, de_valid}, 32'd0);
    chk("E_flush_cnt", {16'd0, stall_cnt}, 32'd5);
    ex_flush = 1'b0;
    #1 chk("E_r5_free_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    chk("E_r5_valid", {31'd0, de_valid}, 32'd1);
    chk("E_r5_dst", {27'd0, de_dst}, 32'd6);
    chk("E_r5_pc", de_pc, 32'h10);

    // addi r0 never marks r0 busy
    fe_pc = 32'h14; fe_isn = 32'h20000007;
    #1 chk("F_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    chk("F_dst", {27'd0, de_dst}, 32'd0);
    chk("F_wr", {31'd0, de_wr}, 32'd1);
    fe_pc = 32'h18; fe_isn = 32'h00003820;
    #1 chk("F_cons_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    chk("F_cons_valid", {31'd0, de_valid}, 32'd1);
    chk("F_cons_dst", {27'd0, de_dst}, 32'd7);
    chk("F_cnt", {16'd0, stall_cnt}, 32'd5);

    // Long hazard on r2 saturates the counter, then reset mid-stall
    fe_pc = 32'h1C; fe_isn = 32'h00424020;
    #1 chk("G_fe_ctr", {30'd0, fe_ctr}, 32'h2);
    repeat (65540) step();
    chk("G_sat_cnt", {16'd0, stall_cnt}, 32'h0000FFFF);
    chk("G_sat_fe_ctr", {30'd0, fe_ctr}, 32'h2);
    #2 rst = 1'b0;
    #1;
    chk("G_rst_cnt", {16'd0, stall_cnt}, 32'd0);
    chk("G_rst_valid", {31'd0, de_valid}, 32'd0);
    chk("G_rst_pc", de_pc, 32'd0);
    chk("G_rst_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    #1 chk("G_post_fe_ctr", {30'd0, fe_ctr}, 32'd0);
    step();
    chk("G_post_valid", {31'd0, de_valid}, 32'd1);
    chk("G_post_dst", {27'd0, de_dst}, 32'd8);
    chk("G_post_pc", de_pc, 32'h1C);

    // beq: no destination
    fe_pc = 32'h20; fe_isn = 32'h10E70003;
    step();
    chk("H_wr", {31'd0, de_wr}, 32'd0);
    chk("H_dst", {27'd0, de_dst}, 32'd0);
    chk("H_rs", {27'd0, de_rs}, 32'd7);
    chk("H_rt", {27'd0, de_rt}, 32'd7);
    chk("H_imm", {16'd0, de_imm}, 32'd3);
    chk("H_opcode", {26'd0, de_opcode}, 32'd4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/de_stage.md
DE_STAGE -- requirements
Module: DE_Stage

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: asynchronous, active-low reset.
REQ-003 SHALL have port fe_pc, input, 32 bits: PC of the instruction currently presented by fetch.
REQ-004 SHALL have port fe_isn, input, 32 bits: instruction word at fe_pc.
REQ-005 SHALL have port ex_stall, input, 1 bit: downstream cannot accept; hold the output register.
REQ-006 SHALL have port ex_flush, input, 1 bit: discard the DE output instruction and the current fetch instruction.
REQ-007 SHALL have ports wb_en (input, 1 bit) and wb_rd (input, 5 bits): writeback of register wb_rd completes this cycle.
REQ-008 SHALL have port fe_ctr, output, 2 bits: 2'b10 = fetch hold, 2'b00 = fetch advance; combinational.
REQ-009 SHALL have outputs de_valid (1), de_pc (32), de_opcode (6), de_rs (5), de_rt (5), de_dst (5), de_wr (1), de_imm (16): registered decoded instruction.
REQ-010 SHALL have port stall_cnt, output, 16 bits: saturating count of cycles with fe_ctr == 2'b10.

Function
REQ-011 SHALL decode fields as: opcode = isn[31:26], rs = isn[25:21], rt = isn[20:16], rd = isn[15:11], imm = isn[15:0].
REQ-012 SHALL select the destination as follows: opcode 0x00 -> rd; opcode 0x08-0x0F or 0x20-0x25 -> rt; all other opcodes -> none (de_wr = 0, de_dst = 0).
REQ-013 SHALL treat rs as a source for every opcode except 0x02 and 0x03, and rt as a source for opcode 0x00, 0x04, 0x05 and 0x28-0x2B.
REQ-014 SHALL hold a 32-bit scoreboard busy[31:0]; busy[0] SHALL always read 0, and no instruction writing r0 sets it.
REQ-015 SHALL set hazard when any used source register, or a destination register with de_wr = 1, is busy, unless wb_en = 1 and wb_rd equals that register in the same cycle (writeback bypass).
REQ-016 SHALL compute issue = !hazard & !ex_stall & !ex_flush.
REQ-017 SHALL drive fe_ctr = 2'b10 when !issue & !ex_flush, and 2'b00 otherwise.
REQ-018 When issue is true, SHALL load all de_* fields from fe_pc/fe_isn at the next edge, set de_valid = 1, and set busy[dst] if de_wr = 1.
REQ-019 When hazard is true and ex_stall is false (no flush), SHALL clear de_valid (insert a bubble) and leave the other de_* fields don't-care.
REQ-020 When ex_stall is true (no flush), SHALL hold every de_* output unchanged.
REQ-021 When ex_flush is true:
- SHALL clear de_valid.
- SHALL clear busy[de_dst] if de_valid and de_wr were both set.
- SHALL NOT issue the instruction currently presented by fetch.
- Flush SHALL take priority over ex_stall and hazard.
REQ-022 SHALL clear busy[wb_rd] when wb_en = 1; if the same register is set by an issue in the same cycle, the set SHALL win.
REQ-023 SHALL increment stall_cnt once per cycle in which fe_ctr == 2'b10, saturating at 16'hFFFF.
REQ-024 Latency: an instruction that is stall-free SHALL appear on de_* exactly one cycle after it is presented on fe_pc/fe_isn.

Reset
REQ-025 While rst = 0, SHALL asynchronously force de_valid = 0, all other de_* = 0, busy = 0 and stall_cnt = 0.
REQ-026 In the first cycle after rst returns to 1, SHALL treat fetch input as valid and allow it to issue.
REQ-027 SHALL apply reset asserted mid-stall immediately: fe_ctr = 2'b00 while rst = 0 and no busy bits survive.

Verification
REQ-028 Sequence: fe_isn = 0x20010005 (addi r1) then 0x00211020 (add r2,r1,r1), no writeback. Required response: the first issues with de_dst = 1 and de_wr = 1; the second gives fe_ctr = 2'b10, de_valid = 0, and stall_cnt increments each cycle.
REQ-029 Continuing REQ-028: assert wb_en = 1 with wb_rd = 1 for one cycle. Required response: in that same cycle, issue fires and fe_ctr = 2'b00; next cycle de_dst = 2 and de_pc = 0x4.
REQ-030 Hold ex_stall = 1 for 3 cycles with a valid de_* instruction. Required response: de_* is unchanged, fe_ctr = 2'b10, and stall_cnt rises by 3.
REQ-031 Assert ex_flush while de_dst = 5 and de_wr = 1. Required response: next cycle de_valid = 0, busy[5] = 0, fe_ctr = 2'b00 during the flush cycle.
REQ-032 Issue 0x20000007 (addi r0). Required response: busy stays 0, and an immediate consumer of r0 issues without a stall.
REQ-033 Force 65540 consecutive hazard cycles, then assert rst = 0 mid-stall. Required response: stall_cnt = 0xFFFF before reset, then immediately 0 with de_valid = 0.
